// File: rtl/msc_xfer_sequencer.sv
// Mass-storage transfer sequencer: walks a SCSI command sector by sector
// between the sector buffer and the drive HAL, then reports status.
module msc_xfer_sequencer #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_W           = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_dir,
   input  logic [31:0] cmd_lba,
   input  logic [15:0] cmd_count,
   input  logic        abort,
   output logic        buf_start,
   output logic        buf_dir,
   output logic [15:0] buf_count,
   input  logic [15:0] buf_sectors_completed,
   input  logic        buf_sector_ready,
   input  logic        buf_room,
   output logic        hal_req,
   input  logic        hal_ack,
   output logic [31:0] hal_lba,
   output logic        hal_dir,
   input  logic        hal_done,
   input  logic        hal_err,
   output logic        sts_valid,
   output logic        sts_ok,
   output logic [15:0] sts_residue,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ARM,
      S_REQ,
      S_XFER,
      S_DRAIN,
      S_STATUS
   } state_t;

   // Last watchdog value before the limit; the next count reaches TIMEOUT_CYCLES.
   localparam logic [TO_W-1:0] WD_LIM = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] WD_ONE = {{(TO_W-1){1'b0}}, 1'b1};

   state_t         state_q, state_d;
   logic           dir_q, dir_d;
   logic [31:0]    lba_q, lba_d;
   logic [15:0]    count_q, count_d;
   logic [15:0]    n_q, n_d;
   logic           ok_q, ok_d;
   logic [TO_W-1:0] wd_q, wd_d;

   logic [TO_W-1:0] wd_inc;
   logic            wd_hit;
   logic            src_ok;
   logic            last;
   logic            abort_hit;

   assign wd_inc    = (wd_q == {TO_W{1'b1}}) ? wd_q : wd_q + WD_ONE;
   assign wd_hit    = (wd_q >= WD_LIM);
   assign src_ok    = dir_q ? buf_room : buf_sector_ready;
   assign last      = ((n_q + 16'd1) == count_q);
   assign abort_hit = abort && (state_q != S_IDLE)
                            && (state_q != S_STATUS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         dir_q   <= 1'b0;
         lba_q   <= '0;
         count_q <= '0;
         n_q     <= '0;
         ok_q    <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         lba_q   <= lba_d;
         count_q <= count_d;
         n_q     <= n_d;
         ok_q    <= ok_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      lba_d     = lba_q;
      count_d   = count_q;
      n_d       = n_q;
      ok_d      = ok_q;
      wd_d      = wd_q;
      cmd_ready = 1'b0;
      buf_start = 1'b0;
      hal_req   = 1'b0;
      sts_valid = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               dir_d   = cmd_dir;
               lba_d   = cmd_lba;
               count_d = cmd_count;
               n_d     = '0;
               if (cmd_count == 16'd0) begin
                  state_d = S_STATUS;
                  ok_d    = 1'b1;
               end else begin
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            buf_start = 1'b1;
            state_d   = S_ARM;
         end
         S_ARM: begin
            if (src_ok) begin
               state_d = S_REQ;
               wd_d    = '0;
            end
         end
         S_REQ: begin
            hal_req = 1'b1;
            wd_d    = wd_inc;
            // A done arriving with the ack is ignored; only XFER honours it.
            if (wd_hit) begin
               state_d = S_STATUS;
               ok_d    = 1'b0;
            end else if (hal_ack) begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            wd_d = wd_inc;
            if (hal_done) begin
               if (hal_err) begin
                  state_d = S_STATUS;
                  ok_d    = 1'b0;
               end else begin
                  n_d = n_q + 16'd1;
                  if (!last) begin
                     state_d = S_ARM;
                  end else if (dir_q) begin
                     state_d = S_DRAIN;
                  end else begin
                     state_d = S_STATUS;
                     ok_d    = 1'b1;
                  end
               end
            end else if (wd_hit) begin
               state_d = S_STATUS;
               ok_d    = 1'b0;
            end
         end
         S_DRAIN: begin
            if (buf_sectors_completed == count_q) begin
               state_d = S_STATUS;
               ok_d    = 1'b1;
            end
         end
         S_STATUS: begin
            sts_valid = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort_hit) begin
         state_d = S_STATUS;
         ok_d    = 1'b0;
         n_d     = n_q;
         hal_req = 1'b0;
      end
   end

   assign buf_dir     = dir_q;
   assign buf_count   = count_q;
   assign hal_dir     = dir_q;
   assign hal_lba     = lba_q + {16'h0000, n_q};
   assign sts_ok      = ok_q;
   assign sts_residue = count_q - n_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_msc_xfer_sequencer.sv
// Directed bench for msc_xfer_sequencer with a HAL responder and an
// output monitor; each scenario task checks its own hand-computed values.
module tb_msc_xfer_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_dir;
   logic [31:0] cmd_lba;
   logic [15:0] cmd_count;
   logic        abort;
   logic        buf_start;
   logic        buf_dir;
   logic [15:0] buf_count;
   logic [15:0] buf_sectors_completed;
   logic        buf_sector_ready;
   logic        buf_room;
   logic        hal_req;
   logic        hal_ack;
   logic [31:0] hal_lba;
   logic        hal_dir;
   logic        hal_done = 1'b0;
   logic        hal_err  = 1'b0;
   logic        sts_valid;
   logic        sts_ok;
   logic [15:0] sts_residue;
   logic        busy;

   int errors = 0;
   int checks = 0;

   logic ack_en = 1'b0;
   int   err_abs = -1;

   int cyc = 0, acc_cyc = 0, bs_cyc = 0, done_cyc = 0;
   int req_cyc = 0, abort_cyc = 0, s_cyc = 0;
   int nbs = 0, nsts = 0, nreq = 0, hs_cnt = 0, done_cnt = 0;
   logic [15:0] bs_cnt = '0, s_res = '0, s_comp = '0;
   logic        bs_dir = 1'b0, s_ok = 1'b0, prev_req = 1'b0;
   logic [31:0] lbas[$];

   msc_xfer_sequencer #(
      .TIMEOUT_CYCLES(16),
      .TO_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir),
      .cmd_lba(cmd_lba),
      .cmd_count(cmd_count),
      .abort(abort),
      .buf_start(buf_start),
      .buf_dir(buf_dir),
      .buf_count(buf_count),
      .buf_sectors_completed(buf_sectors_completed),
      .buf_sector_ready(buf_sector_ready),
      .buf_room(buf_room),
      .hal_req(hal_req),
      .hal_ack(hal_ack),
      .hal_lba(hal_lba),
      .hal_dir(hal_dir),
      .hal_done(hal_done),
      .hal_err(hal_err),
      .sts_valid(sts_valid),
      .sts_ok(sts_ok),
      .sts_residue(sts_residue),
      .busy(busy)
   );

   always #5 clk = ~clk;

   assign hal_ack = ack_en & hal_req;

   always @(negedge clk) begin
      cyc++;
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (buf_start) begin
         nbs++;
         bs_cyc = cyc;
         bs_cnt = buf_count;
         bs_dir = buf_dir;
      end
      if (hal_req) nreq++;
      if (hal_req && !prev_req) req_cyc = cyc;
      prev_req = hal_req;
      if (hal_req && hal_ack) begin
         hs_cnt++;
         lbas.push_back(hal_lba);
      end
      if (hal_done) done_cyc = cyc;
      if (abort) abort_cyc = cyc;
      if (sts_valid) begin
         nsts++;
         s_ok   = sts_ok;
         s_res  = sts_residue;
         s_cyc  = cyc;
         s_comp = buf_sectors_completed;
      end
   end

   // HAL finishes each accepted sector in the cycle right after the ack.
   always begin
      @(posedge clk);
      #1;
      hal_done = (hs_cnt != done_cnt);
      hal_err  = hal_done && (done_cnt == err_abs);
      if (hal_done) done_cnt++;
   end

   task automatic issue(input logic d, input logic [31:0] l,
                        input logic [15:0] c);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_lba   = l;
      cmd_count = c;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_sts(input int base, output bit got);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (nsts > base) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_busy: got %b/%b want 1/0", cmd_ready, busy);
      end
      checks++;
      if ({buf_start, hal_req, sts_valid, sts_ok} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_pulses: got %b want 0000",
                  {buf_start, hal_req, sts_valid, sts_ok});
      end
      checks++;
      if (buf_count !== 16'h0 || hal_lba !== 32'h0 || sts_residue !== 16'h0) begin
         errors++;
         $display("FAIL reset_fields: got %h/%h/%h want 0/0/0",
                  buf_count, hal_lba, sts_residue);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_write_basic;
      int bb = nbs, bs = nsts, bl = lbas.size();
      bit got;
      issue(1'b0, 32'h100, 16'd2);
      wait_sts(bs, got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL wr_sts_timeout: got no sts_valid want one");
      end
      checks++;
      if (nbs - bb !== 1 || bs_cnt !== 16'd2 || bs_dir !== 1'b0) begin
         errors++;
         $display("FAIL wr_buf_start: got n=%0d cnt=%0d dir=%b want 1/2/0",
                  nbs - bb, bs_cnt, bs_dir);
      end
      checks++;
      if (bs_cyc - acc_cyc !== 1) begin
         errors++;
         $display("FAIL wr_start_lat: got %0d want 1", bs_cyc - acc_cyc);
      end
      checks++;
      if (lbas.size() - bl !== 2 || lbas[bl] !== 32'h100 || lbas[bl+1] !== 32'h101) begin
         errors++;
         $display("FAIL wr_lbas: got n=%0d want 2 of 0x100,0x101", lbas.size() - bl);
      end
      checks++;
      if (s_ok !== 1'b1 || s_res !== 16'd0) begin
         errors++;
         $display("FAIL wr_status: got ok=%b res=%0d want 1/0", s_ok, s_res);
      end
      checks++;
      if (s_cyc - done_cyc !== 1) begin
         errors++;
         $display("FAIL wr_done_lat: got %0d want 1", s_cyc - done_cyc);
      end
   endtask

   task automatic test_read_drain;
      int bs = nsts, bd = done_cnt, bl = lbas.size();
      bit got;
      buf_sectors_completed = 16'd0;
      issue(1'b1, 32'h2000, 16'd3);
      for (int i = 0; i < 100 && done_cnt < bd + 3; i++) @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (nsts !== bs || busy !== 1'b1) begin
         errors++;
         $display("FAIL rd_drain_hold: got sts=%0d busy=%b want %0d/1", nsts, busy, bs);
      end
      @(posedge clk);
      #1;
      buf_sectors_completed = 16'd3;
      wait_sts(bs, got);
      checks++;
      if (!got || s_comp !== 16'd3) begin
         errors++;
         $display("FAIL rd_sts_after_done: got sts=%b comp=%0d want 1/3", got, s_comp);
      end
      checks++;
      if (s_ok !== 1'b1 || s_res !== 16'd0 || bs_dir !== 1'b1) begin
         errors++;
         $display("FAIL rd_status: got ok=%b res=%0d dir=%b want 1/0/1", s_ok, s_res, bs_dir);
      end
      checks++;
      if (lbas.size() - bl !== 3 || lbas[bl+2] !== 32'h2002) begin
         errors++;
         $display("FAIL rd_lbas: got n=%0d want 3 ending 0x2002", lbas.size() - bl);
      end
      buf_sectors_completed = 16'd0;
   endtask

   task automatic test_zero_count;
      int bb = nbs, bs = nsts, br = nreq;
      bit got;
      issue(1'b0, 32'h5, 16'd0);
      wait_sts(bs, got);
      checks++;
      if (!got || nbs !== bb || nreq !== br) begin
         errors++;
         $display("FAIL zero_no_xfer: got sts=%b starts=%0d reqs=%0d want 1/0/0",
                  got, nbs - bb, nreq - br);
      end
      checks++;
      if (s_ok !== 1'b1 || s_res !== 16'd0 || s_cyc - acc_cyc !== 1) begin
         errors++;
         $display("FAIL zero_status: got ok=%b res=%0d lat=%0d want 1/0/1",
                  s_ok, s_res, s_cyc - acc_cyc);
      end
   endtask

   task automatic test_hal_err;
      int bs = nsts;
      bit got;
      err_abs = done_cnt + 1;
      issue(1'b0, 32'h40, 16'd4);
      wait_sts(bs, got);
      checks++;
      if (!got || s_ok !== 1'b0 || s_res !== 16'd3) begin
         errors++;
         $display("FAIL hal_err: got sts=%b ok=%b res=%0d want 1/0/3", got, s_ok, s_res);
      end
      err_abs = -1;
   endtask

   task automatic test_timeout;
      int bs = nsts;
      bit got;
      ack_en = 1'b0;
      issue(1'b0, 32'h7, 16'd1);
      wait_sts(bs, got);
      checks++;
      if (!got || s_ok !== 1'b0 || s_res !== 16'd1) begin
         errors++;
         $display("FAIL timeout_status: got sts=%b ok=%b res=%0d want 1/0/1", got, s_ok, s_res);
      end
      checks++;
      if (s_cyc - req_cyc !== 16) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d want 16", s_cyc - req_cyc);
      end
      ack_en = 1'b1;
   endtask

   task automatic test_abort_arm;
      int bs = nsts;
      bit got;
      buf_sector_ready = 1'b0;
      issue(1'b0, 32'h80, 16'd2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || hal_req !== 1'b0) begin
         errors++;
         $display("FAIL abort_arm_wait: got busy=%b req=%b want 1/0", busy, hal_req);
      end
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      wait_sts(bs, got);
      checks++;
      if (!got || s_ok !== 1'b0 || s_res !== 16'd2 || s_cyc - abort_cyc !== 1) begin
         errors++;
         $display("FAIL abort_arm: got sts=%b ok=%b res=%0d lat=%0d want 1/0/2/1",
                  got, s_ok, s_res, s_cyc - abort_cyc);
      end
      buf_sector_ready = 1'b1;
   endtask

   task automatic test_abort_req;
      int bs = nsts;
      bit got;
      ack_en = 1'b0;
      issue(1'b0, 32'h90, 16'd1);
      for (int i = 0; i < 20 && hal_req !== 1'b1; i++) @(negedge clk);
      @(posedge clk);
      #1;
      abort = 1'b1;
      #1;
      checks++;
      if (hal_req !== 1'b0) begin
         errors++;
         $display("FAIL abort_req_drop: got hal_req=%b want 0", hal_req);
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      wait_sts(bs, got);
      checks++;
      if (!got || s_ok !== 1'b0 || s_cyc - abort_cyc !== 1) begin
         errors++;
         $display("FAIL abort_req: got sts=%b ok=%b lat=%0d want 1/0/1",
                  got, s_ok, s_cyc - abort_cyc);
      end
      ack_en = 1'b1;
   endtask

   task automatic test_lba_wrap;
      int bs = nsts, bl = lbas.size();
      bit got;
      issue(1'b0, 32'hFFFF_FFFF, 16'd2);
      wait_sts(bs, got);
      checks++;
      if (!got || lbas.size() - bl !== 2 || lbas[bl] !== 32'hFFFF_FFFF
          || lbas[bl+1] !== 32'h0) begin
         errors++;
         $display("FAIL lba_wrap: got sts=%b n=%0d want 1/2 of FFFFFFFF,0",
                  got, lbas.size() - bl);
      end
   endtask

   task automatic test_back_to_back;
      int bb = nbs, bs = nsts, bl = lbas.size();
      bit got;
      issue(1'b0, 32'h20, 16'd1);
      cmd_valid = 1'b1;
      cmd_lba   = 32'h40;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready_%0d: got %b want 0", i, cmd_ready);
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_sts(bs, got);
      checks++;
      if (!got || nbs - bb !== 1 || lbas.size() - bl !== 1 || lbas[bl] !== 32'h20) begin
         errors++;
         $display("FAIL busy_ignored: got starts=%0d sectors=%0d want 1/1",
                  nbs - bb, lbas.size() - bl);
      end
      issue(1'b0, 32'h40, 16'd1);
      wait_sts(bs + 1, got);
      checks++;
      if (!got || s_ok !== 1'b1 || lbas[lbas.size()-1] !== 32'h40) begin
         errors++;
         $display("FAIL b2b_second: got sts=%b ok=%b lba=%h want 1/1/40",
                  got, s_ok, lbas[lbas.size()-1]);
      end
   endtask

   task automatic test_reset_mid;
      int bs = nsts;
      buf_sector_ready = 1'b0;
      issue(1'b0, 32'h300, 16'd3);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || buf_count !== 16'h0 || sts_ok !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_state: got busy=%b rdy=%b cnt=%0d ok=%b want 0/1/0/0",
                  busy, cmd_ready, buf_count, sts_ok);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      buf_sector_ready = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (nsts !== bs) begin
         errors++;
         $display("FAIL reset_mid_silent: got %0d sts pulses want 0", nsts - bs);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_dir = 1'b0;
      cmd_lba = '0;
      cmd_count = '0;
      abort = 1'b0;
      buf_sectors_completed = '0;
      buf_sector_ready = 1'b1;
      buf_room = 1'b1;
      ack_en = 1'b1;
      test_reset();
      test_write_basic();
      test_read_drain();
      test_zero_count();
      test_hal_err();
      test_timeout();
      test_abort_arm();
      test_abort_req();
      test_lba_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/msc_xfer_sequencer.md
MSC_XFER_SEQUENCER -- requirements
Module: msc_xfer_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000; per-sector HAL watchdog limit in clk cycles.
REQ-002 SHALL have parameter TO_W, default 24; width of the watchdog counter.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake from SCSI layer.
REQ-006 cmd_dir  in  1  0=WRITE (host->drive), 1=READ (drive->host).
REQ-007 cmd_lba  in  32  starting LBA.
REQ-008 cmd_count  in  16  sector count.
REQ-009 abort  in  1  host reset/abort request.
REQ-010 buf_start  out  1  one-cycle pulse: start sector-buffer transfer.
REQ-011 buf_dir  out  1  direction to the buffer.
REQ-012 buf_count  out  16  sector count to the buffer.
REQ-013 buf_sectors_completed  in  16  USB-side sectors completed, reported by the buffer.
REQ-014 buf_sector_ready  in  1  full sector held in buffer (WRITE path).
REQ-015 buf_room  in  1  buffer has space for one sector (READ path).
REQ-016 hal_req / hal_ack  out / in  1 / 1  sector request handshake to the drive HAL.
REQ-017 hal_lba  out  32  LBA of the current sector.
REQ-018 hal_dir  out  1  direction of the current sector.
REQ-019 hal_done / hal_err  in / in  1 / 1  sector finished; error flag, sampled with hal_done.
REQ-020 sts_valid  out  1  one-cycle pulse: status available.
REQ-021 sts_ok  out  1  1=pass, 0=fail.
REQ-022 sts_residue  out  16  sectors not transferred.
REQ-023 busy  out  1  high in every state except IDLE.

Function
REQ-024 SHALL implement states IDLE, START, ARM, REQ, XFER, DRAIN, STATUS.
REQ-025 IDLE: cmd_ready=1; on cmd_valid, latch dir, lba, count; clear sector counter n; go to START. If count==0, go directly to STATUS with ok=1, residue=0, and issue no buf_start.
REQ-026 START: pulse buf_start for exactly 1 cycle with buf_dir/buf_count = latched values; go to ARM.
REQ-027 ARM: wait for buf_sector_ready (WRITE) or buf_room (READ); then go to REQ.
REQ-028 REQ: hold hal_req=1, hal_lba=lba+n (32-bit, wraps modulo 2^32), hal_dir=dir stable until hal_ack; on hal_ack go to XFER; hal_req deasserts the cycle after ack.
REQ-029 XFER: on hal_done with hal_err=0, increment n; if n+1==count go to DRAIN, else go to ARM. On hal_done with hal_err=1, go to STATUS with ok=0.
REQ-030 Watchdog: counter clears on entry to REQ and counts every cycle in REQ/XFER; on reaching TIMEOUT_CYCLES, go to STATUS with ok=0; it saturates and never wraps.
REQ-031 DRAIN (READ only; WRITE skips DRAIN and goes straight to STATUS ok=1): wait for buf_sectors_completed==count, then go to STATUS with ok=1.
REQ-032 STATUS: pulse sts_valid for 1 cycle; sts_residue=count-n (16-bit); go to IDLE.
REQ-033 abort in any state other than IDLE/STATUS SHALL force STATUS next cycle with ok=0; hal_req drops immediately.
REQ-034 hal_ack and hal_done in the same cycle in REQ SHALL be treated as ack only; done is only honoured in XFER.
REQ-035 cmd_valid while busy SHALL be ignored (cmd_ready=0).
REQ-036 Handshake latency: cmd accept to buf_start = 1 cycle; hal_done(ok, last) to sts_valid = 1 cycle (WRITE).

Reset
REQ-037 On rst_n low: state=IDLE; cmd_ready=1; buf_start=0, hal_req=0, sts_valid=0, sts_ok=0, busy=0; all counters, latched fields and buf_count/hal_lba=0.
REQ-038 Reset mid-transfer SHALL abandon it silently, with no sts_valid pulse.

Verification
REQ-039 WRITE lba=0x100 count=2, ready/ack/done immediate -> buf_start once, hal_lba 0x100 then 0x101, sts_ok=1, residue=0.
REQ-040 READ count=3, buf_sectors_completed reaches 3 ten cycles after the last hal_done -> sts_valid only after completed==3.
REQ-041 count=0 -> no buf_start, no hal_req, sts_valid with ok=1, residue=0.
REQ-042 hal_err on the 2nd of 4 sectors -> sts_ok=0, residue=3.
REQ-043 TIMEOUT_CYCLES=16, hal_ack never asserted -> sts_ok=0 exactly 16 cycles after REQ entry; abort in ARM -> sts_ok=0 next cycle.
REQ-044 lba=0xFFFFFFFF count=2 -> hal_lba 0xFFFFFFFF then 0x00000000.
